// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller.
// fwd_sel_t  : EX-stage operand source select (register file, W result, M ALU result)
// hz_state_t : MDU sequencing state (RUN = pipeline flowing, BUSY = MDU holding E)
// REG_ZERO   : index of the hard-wired zero register, which is never forwarded
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    HZ_RUN  = 1'b0,
    HZ_BUSY = 1'b1
  } hz_state_t;

  localparam int REG_ZERO = 0;

endpackage

// File: rtl/fwd_sel.sv
// Forwarding select for one EX-stage source operand.
// Ports:
//   src      : source register index read in E
//   rd_M     : destination register of the instruction in M
//   rd_W     : destination register of the instruction in W
//   reg_we_M : M-stage instruction writes rd_M
//   reg_we_W : W-stage instruction writes rd_W
//   sel      : FWD_M, FWD_W or FWD_RF
module fwd_sel
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] src,
  input  logic [REG_AW-1:0] rd_M,
  input  logic [REG_AW-1:0] rd_W,
  input  logic              reg_we_M,
  input  logic              reg_we_W,
  output fwd_sel_t          sel
);

  localparam logic [REG_AW-1:0] ZERO_IDX = REG_AW'(REG_ZERO);

  // M is checked first because it holds the younger write to the register.
  always_comb begin
    sel = FWD_RF;
    if (reg_we_M && (rd_M != ZERO_IDX) && (rd_M == src)) begin
      sel = FWD_M;
    end else if (reg_we_W && (rd_W != ZERO_IDX) && (rd_W == src)) begin
      sel = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller for the 5-stage core.
// Generates operand forwarding selects, load-use stalls, branch flushes,
// multi-cycle stalls for the iterative MDU and a saturating stall counter.
// Ports:
//   clk, reset               : clock and synchronous active-low reset
//   rs1_D, rs2_D             : decode-stage sources (load-use check)
//   rs1_E, rs2_E, rd_E       : execute-stage sources and destination
//   rd_M, rd_W               : M/W destinations, with reg_we_M / reg_we_W
//   load_E, pc_src_E         : load in E, branch/jump taken in E
//   mdu_start_E              : MDU op in E
//   forward_A, forward_B     : operand selects (00 RF, 01 W, 10 M)
//   stall_F/D/E, flush_D/E/M : pipeline register controls
//   mdu_busy                 : MDU is holding E
//   stall_count              : cycles with stall_F asserted, saturating
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int REG_AW      = 5,
  parameter int MDU_LATENCY = 4,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] rs1_D,
  input  logic [REG_AW-1:0] rs2_D,
  input  logic [REG_AW-1:0] rs1_E,
  input  logic [REG_AW-1:0] rs2_E,
  input  logic [REG_AW-1:0] rd_E,
  input  logic [REG_AW-1:0] rd_M,
  input  logic [REG_AW-1:0] rd_W,
  input  logic              reg_we_M,
  input  logic              reg_we_W,
  input  logic              load_E,
  input  logic              pc_src_E,
  input  logic              mdu_start_E,
  output logic [1:0]        forward_A,
  output logic [1:0]        forward_B,
  output logic              stall_F,
  output logic              stall_D,
  output logic              stall_E,
  output logic              flush_D,
  output logic              flush_E,
  output logic              flush_M,
  output logic              mdu_busy,
  output logic [CNT_W-1:0]  stall_count
);

  // Counter only needs to hold MDU_LATENCY-2; width is kept >= 1 so
  // MDU_LATENCY==1 still elaborates.
  localparam int MDU_W = $clog2(MDU_LATENCY + 1);
  localparam int MDU_LOAD = (MDU_LATENCY > 1) ? (MDU_LATENCY - 2) : 0;
  localparam logic [REG_AW-1:0] ZERO_IDX = REG_AW'(REG_ZERO);

  hz_state_t        state, state_next;
  logic [MDU_W-1:0] mdu_cnt, mdu_cnt_next;
  fwd_sel_t         fwd_a, fwd_b;
  logic             load_use;

  fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
    .src      (rs1_E),
    .rd_M     (rd_M),
    .rd_W     (rd_W),
    .reg_we_M (reg_we_M),
    .reg_we_W (reg_we_W),
    .sel      (fwd_a)
  );

  fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
    .src      (rs2_E),
    .rd_M     (rd_M),
    .rd_W     (rd_W),
    .reg_we_M (reg_we_M),
    .reg_we_W (reg_we_W),
    .sel      (fwd_b)
  );

  assign load_use = load_E && (rd_E != ZERO_IDX) &&
                    ((rd_E == rs1_D) || (rd_E == rs2_D));

  // State register, MDU countdown and saturating stall counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= HZ_RUN;
      mdu_cnt     <= '0;
      stall_count <= '0;
    end else begin
      state   <= state_next;
      mdu_cnt <= mdu_cnt_next;
      if (stall_F && (stall_count != {CNT_W{1'b1}})) begin
        stall_count <= stall_count + CNT_W'(1);
      end
    end
  end

  // Next state: the start cycle counts as the first MDU cycle, so BUSY
  // lasts MDU_LATENCY-1 cycles (counter runs MDU_LATENCY-2 down to 0).
  always_comb begin
    state_next   = state;
    mdu_cnt_next = mdu_cnt;
    case (state)
      HZ_RUN: begin
        if (mdu_start_E && (MDU_LATENCY > 1)) begin
          state_next   = HZ_BUSY;
          mdu_cnt_next = MDU_W'(MDU_LOAD);
        end
      end
      HZ_BUSY: begin
        if (mdu_cnt == '0) begin
          state_next = HZ_RUN;
        end else begin
          mdu_cnt_next = mdu_cnt - MDU_W'(1);
        end
      end
      default: state_next = HZ_RUN;
    endcase
  end

  // Outputs. In BUSY the MDU op is held in E, so load-use and branch are
  // ignored; a taken branch suppresses the load-use stall since the
  // stalled instruction is being flushed anyway.
  always_comb begin
    forward_A = 2'b00;
    forward_B = 2'b00;
    stall_F   = 1'b0;
    stall_D   = 1'b0;
    stall_E   = 1'b0;
    flush_D   = 1'b0;
    flush_E   = 1'b0;
    flush_M   = 1'b0;
    mdu_busy  = 1'b0;
    if (reset) begin
      forward_A = fwd_a;
      forward_B = fwd_b;
      if (state == HZ_BUSY) begin
        stall_F  = 1'b1;
        stall_D  = 1'b1;
        stall_E  = 1'b1;
        flush_M  = 1'b1;
        mdu_busy = 1'b1;
      end else begin
        stall_F = load_use && !pc_src_E;
        stall_D = load_use && !pc_src_E;
        flush_E = load_use || pc_src_E;
        flush_D = pc_src_E;
      end
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit (MDU_LATENCY=4, CNT_W=4 so that
// counter saturation is reachable quickly). A behavioural model tracks the
// number of remaining MDU busy cycles and the stall count as plain integers.
module tb_hazard_unit;

  localparam int REG_AW  = 5;
  localparam int MDU_LAT = 4;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              reset;
  logic [REG_AW-1:0] rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W;
  logic              reg_we_M, reg_we_W, load_E, pc_src_E, mdu_start_E;
  logic [1:0]        forward_A, forward_B;
  logic              stall_F, stall_D, stall_E, flush_D, flush_E, flush_M, mdu_busy;
  logic [CNT_W-1:0]  stall_count;

  int n_assert = 0;
  int n_fail   = 0;

  // model state
  int m_busy_left = 0;
  int m_count     = 0;
  int e_fA, e_fB, e_sF, e_sD, e_sE, e_fD, e_fE, e_fM, e_busy;

  hazard_unit #(.REG_AW(REG_AW), .MDU_LATENCY(MDU_LAT), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .rs1_D       (rs1_D),
    .rs2_D       (rs2_D),
    .rs1_E       (rs1_E),
    .rs2_E       (rs2_E),
    .rd_E        (rd_E),
    .rd_M        (rd_M),
    .rd_W        (rd_W),
    .reg_we_M    (reg_we_M),
    .reg_we_W    (reg_we_W),
    .load_E      (load_E),
    .pc_src_E    (pc_src_E),
    .mdu_start_E (mdu_start_E),
    .forward_A   (forward_A),
    .forward_B   (forward_B),
    .stall_F     (stall_F),
    .stall_D     (stall_D),
    .stall_E     (stall_E),
    .flush_D     (flush_D),
    .flush_E     (flush_E),
    .flush_M     (flush_M),
    .mdu_busy    (mdu_busy),
    .stall_count (stall_count)
  );

  always #5 clk = ~clk;

  function automatic int refFwd(input int src);
    if (reg_we_M && rd_M != 0 && int'(rd_M) == src) return 2;
    if (reg_we_W && rd_W != 0 && int'(rd_W) == src) return 1;
    return 0;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Derive expected outputs from the current inputs and model state.
  task automatic checkOutput();
    int lu;
    e_fA = 0; e_fB = 0; e_sF = 0; e_sD = 0; e_sE = 0;
    e_fD = 0; e_fE = 0; e_fM = 0; e_busy = 0;
    if (reset) begin
      e_fA = refFwd(int'(rs1_E));
      e_fB = refFwd(int'(rs2_E));
      if (m_busy_left > 0) begin
        e_sF = 1; e_sD = 1; e_sE = 1; e_fM = 1; e_busy = 1;
      end else begin
        lu = (load_E && rd_E != 0 && (rd_E == rs1_D || rd_E == rs2_D)) ? 1 : 0;
        e_fD = pc_src_E ? 1 : 0;
        e_fE = (lu == 1 || pc_src_E) ? 1 : 0;
        e_sF = (lu == 1 && !pc_src_E) ? 1 : 0;
        e_sD = e_sF;
      end
    end
    chk("forward_A",   int'(forward_A),   e_fA);
    chk("forward_B",   int'(forward_B),   e_fB);
    chk("stall_F",     int'(stall_F),     e_sF);
    chk("stall_D",     int'(stall_D),     e_sD);
    chk("stall_E",     int'(stall_E),     e_sE);
    chk("flush_D",     int'(flush_D),     e_fD);
    chk("flush_E",     int'(flush_E),     e_fE);
    chk("flush_M",     int'(flush_M),     e_fM);
    chk("mdu_busy",    int'(mdu_busy),    e_busy);
    chk("stall_count", int'(stall_count), m_count);
  endtask

  // One cycle: check settled outputs, clock, advance the model, then move
  // to the falling edge where the caller drives the next inputs.
  task automatic applyStimulus();
    #1;
    checkOutput();
    @(posedge clk);
    if (!reset) begin
      m_busy_left = 0;
      m_count     = 0;
    end else begin
      if (e_sF == 1 && m_count < CNT_MAX) m_count++;
      if (m_busy_left > 0) m_busy_left--;
      else if (mdu_start_E && MDU_LAT > 1) m_busy_left = MDU_LAT - 1;
    end
    @(negedge clk);
  endtask

  task automatic clearInputs();
    rs1_D = '0; rs2_D = '0; rs1_E = '0; rs2_E = '0; rd_E = '0;
    rd_M = '0; rd_W = '0; reg_we_M = 0; reg_we_W = 0;
    load_E = 0; pc_src_E = 0; mdu_start_E = 0;
  endtask

  initial begin
    reset = 1'b0;
    clearInputs();
    @(posedge clk);
    @(negedge clk);

    // reset holds forwarding at RF, release gives M in the same cycle
    rd_M = 5; rs1_E = 5; reg_we_M = 1;
    applyStimulus();
    reset = 1'b1;
    applyStimulus();

    // M-over-W priority, W alone, register zero
    clearInputs();
    rd_M = 7; rd_W = 7; rs2_E = 7; reg_we_M = 1; reg_we_W = 1;
    applyStimulus();
    reg_we_M = 0;
    applyStimulus();
    reg_we_M = 1; rd_M = 0; rd_W = 0; rs1_E = 0;
    applyStimulus();

    // load-use, then load-use together with a taken branch
    clearInputs();
    load_E = 1; rd_E = 3; rs2_D = 3;
    applyStimulus();
    clearInputs();
    applyStimulus();
    load_E = 1; rd_E = 3; rs2_D = 3; pc_src_E = 1;
    applyStimulus();
    clearInputs();
    applyStimulus();

    // MDU op with a load-use/branch pattern present during BUSY
    mdu_start_E = 1;
    applyStimulus();
    mdu_start_E = 0; load_E = 1; rd_E = 4; rs1_D = 4; pc_src_E = 1;
    for (int i = 0; i < 3; i++) applyStimulus();
    clearInputs();
    applyStimulus();
    applyStimulus();

    // reset during the second BUSY cycle
    mdu_start_E = 1;
    applyStimulus();
    mdu_start_E = 0;
    applyStimulus();
    reset = 1'b0;
    applyStimulus();
    reset = 1'b1;
    applyStimulus();

    // saturation of the stall counter
    load_E = 1; rd_E = 9; rs2_D = 9;
    for (int i = 0; i < 20; i++) applyStimulus();
    clearInputs();
    applyStimulus();

    // random traffic
    for (int i = 0; i < 300; i++) begin
      reset       = ($urandom_range(0, 31) != 0);
      rs1_D       = REG_AW'($urandom_range(0, 7));
      rs2_D       = REG_AW'($urandom_range(0, 7));
      rs1_E       = REG_AW'($urandom_range(0, 7));
      rs2_E       = REG_AW'($urandom_range(0, 7));
      rd_E        = REG_AW'($urandom_range(0, 7));
      rd_M        = REG_AW'($urandom_range(0, 7));
      rd_W        = REG_AW'($urandom_range(0, 7));
      reg_we_M    = 1'($urandom_range(0, 1));
      reg_we_W    = 1'($urandom_range(0, 1));
      load_E      = 1'($urandom_range(0, 1));
      pc_src_E    = ($urandom_range(0, 3) == 0);
      mdu_start_E = ($urandom_range(0, 7) == 0);
      applyStimulus();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
Parametrised pipeline hazard controller for the 5-stage core; supersedes the standalone EX-stage forwarding block.
- Produces forwarding selects for both EX-stage operands with correct M-over-W priority.
- Detects load-use hazards and branch-taken flushes.
- Sequences multi-cycle stalls for the iterative multiply/divide unit (MDU).
- Keeps a saturating stall-cycle counter for performance monitoring.

Parameters:
REG_AW, 5, register index width (2**REG_AW architectural registers; index 0 is hard-wired zero)
MDU_LATENCY, 4, EX-stage cycles an MDU op occupies (>=1; 1 means no extra stall)
CNT_W, 16, width of the stall-cycle counter

Ports:
clk  in  1  core clock
reset  in  1  synchronous, active-low reset
rs1_D  in  REG_AW  decode-stage source 1
rs2_D  in  REG_AW  decode-stage source 2
rs1_E  in  REG_AW  execute-stage source 1
rs2_E  in  REG_AW  execute-stage source 2
rd_E  in  REG_AW  execute-stage destination
rd_M  in  REG_AW  memory-stage destination
rd_W  in  REG_AW  writeback-stage destination
reg_we_M  in  1  M-stage writes rd_M
reg_we_W  in  1  W-stage writes rd_W
load_E  in  1  instruction in E is a load
pc_src_E  in  1  branch/jump taken, resolved in E
mdu_start_E  in  1  instruction in E is an MDU op (valid in RUN only)
forward_A  out  2  operand A select: 00 RF, 01 W result, 10 M ALU result
forward_B  out  2  operand B select, same encoding
stall_F  out  1  hold PC
stall_D  out  1  hold IF/ID register
stall_E  out  1  hold ID/EX register
flush_D  out  1  clear IF/ID register
flush_E  out  1  clear ID/EX register (bubble)
flush_M  out  1  clear EX/MEM register (bubble)
mdu_busy  out  1  FSM in BUSY
stall_count  out  CNT_W  cycles with stall_F asserted, saturating

Behaviour:
- Reset (reset==0 at rising clk): state=RUN, mdu_cnt=0, stall_count=0.
- While reset==0, every combinational output is forced to 0, including both forward selects.
- Forwarding, evaluated independently for src in {rs1_E->forward_A, rs2_E->forward_B}:
  - 10 if reg_we_M && rd_M!=0 && rd_M==src;
  - else 01 if reg_we_W && rd_W!=0 && rd_W==src;
  - else 00.
  - M always wins when M and W both match. Register 0 is never forwarded.
- Load-use, in RUN only: lu = load_E && rd_E!=0 && (rd_E==rs1_D || rd_E==rs2_D).
  - lu drives stall_F=stall_D=flush_E=1 for exactly one cycle.
  - The load advances, so lu self-clears on the next cycle.
- Branch, in RUN only: pc_src_E=1 drives flush_D=flush_E=1.
  - Branch takes priority over lu: stall_F and stall_D are forced to 0 when both occur.
- MDU FSM, states RUN and BUSY:
  - RUN to BUSY when mdu_start_E=1 and MDU_LATENCY>1; mdu_cnt loads MDU_LATENCY-2.
  - BUSY to RUN when mdu_cnt==0; otherwise mdu_cnt decrements each cycle.
  - In BUSY: stall_F=stall_D=stall_E=1, flush_M=1, mdu_busy=1.
  - In BUSY, lu and pc_src_E are ignored, because E is held with the MDU op.
  - Net effect: the MDU op occupies E for exactly MDU_LATENCY cycles, with the start cycle counted as the first.
  - MDU_LATENCY==1: the FSM never leaves RUN.
  - Forward selects are still computed in BUSY. Because M is bubbled, they resolve to W or RF after the first BUSY cycle.
- stall_count: increments each cycle stall_F==1 and saturates at all-ones, with no wrap.
- Reset mid-BUSY: next state RUN, all stalls and flushes deassert on the same clock edge.
- Timing: all outputs are combinational from inputs and current state. There is no added latency.

Decomposition:
- Package hazard_pkg:
  - fwd_sel_t enum (FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10);
  - hz_state_t enum (HZ_RUN, HZ_BUSY);
  - REG_ZERO constant.
- Sub-module fwd_sel: one source index against the M and W destinations, returns fwd_sel_t.
  - Parametrised by REG_AW.
  - Instantiated twice, for A and B.

Test Plan:
- Reset held low with rd_M=rs1_E=5, reg_we_M=1 -> forward_A=00 and all stall/flush outputs 0. Release -> forward_A=10 in the same cycle.
- rd_M=rd_W=rs2_E=7, reg_we_M=reg_we_W=1 -> forward_B=10. reg_we_M=0 -> forward_B=01. rd_M=rd_W=rs1_E=0 -> forward_A=00.
- load_E=1, rd_E=3, rs2_D=3 -> one cycle of stall_F=stall_D=flush_E=1, stall_count 0->1. Repeat with pc_src_E=1 -> flush_D=flush_E=1 and stall_F=0.
- MDU_LATENCY=4, mdu_start_E=1 for one cycle:
  - mdu_busy high for 3 cycles with stall_E=flush_M=1;
  - RUN on the 5th cycle;
  - stall_count +3;
  - a simultaneous lu pattern is ignored in BUSY.
- Reset pulsed low during the 2nd BUSY cycle -> the next cycle is RUN with mdu_busy=0 and stall_count=0.
- Force stall_count near max (CNT_W=4, 20 consecutive load-use stalls) -> count saturates at 15 and does not wrap.
